// File: rtl/pinball_pkg.sv
// Shared types and constants for the pinball playfield blocks: collision FSM
// states, hit classification and pixel coordinate width.
package pinball_pkg;

    localparam int PIX_W            = 11;
    localparam int HOLD_W           = 4;
    localparam int DEFAULT_CENTER_X = 320;

    typedef enum logic [1:0] {
        ARMED,
        CAPTURED,
        HOLDOFF
    } coll_state_t;

    typedef enum logic {
        HIT_FLAT,
        HIT_DIAG
    } hit_type_t;

    typedef struct packed {
        hit_type_t        kind;
        logic [PIX_W-1:0] x;
        logic [PIX_W-1:0] y;
    } hit_rec_t;

    // The diagonal tip wins over the flat section when both cover the pixel.
    function automatic hit_type_t classify_hit(input logic diag_req);
        return diag_req ? HIT_DIAG : HIT_FLAT;
    endfunction

endpackage

// File: rtl/flipper_ball_collision_if.sv
// Bundle between the video/draw pipeline (master) and the flipper/ball
// collision detector (slave).
interface flipper_ball_collision_if;

    logic                          startOfFrame;
    logic [pinball_pkg::PIX_W-1:0] pixelX;
    logic [pinball_pkg::PIX_W-1:0] pixelY;
    logic                          ballDrawReq;
    logic                          flipperDrawReq;
    logic                          diagonalFlipperDrawReq;

    logic                          collisionFlat;
    logic                          collisionDiag;
    logic [pinball_pkg::PIX_W-1:0] hitX;
    logic [pinball_pkg::PIX_W-1:0] hitY;
    logic                          hitSide;
    logic [7:0]                    hitCount;

    modport master (
        output startOfFrame, pixelX, pixelY,
        output ballDrawReq, flipperDrawReq, diagonalFlipperDrawReq,
        input  collisionFlat, collisionDiag, hitX, hitY, hitSide, hitCount
    );

    modport slave (
        input  startOfFrame, pixelX, pixelY,
        input  ballDrawReq, flipperDrawReq, diagonalFlipperDrawReq,
        output collisionFlat, collisionDiag, hitX, hitY, hitSide, hitCount
    );

endinterface

// File: rtl/frame_holdoff_counter.sv
// Loadable down-counter stepped once per frame; done marks the frame boundary
// on which the count runs out (1 -> 0).
module frame_holdoff_counter
    import pinball_pkg::*;
(
    input  logic              clk,
    input  logic              resetN,
    input  logic              load,
    input  logic [HOLD_W-1:0] load_val,
    input  logic              en,
    output logic              done
);

    logic [HOLD_W-1:0] count;

    // NOTE: sequential state is written with non-blocking assignments only.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign done = en && !load && (count == HOLD_W'(1));

endmodule

// File: rtl/flipper_ball_collision.sv
// Captures the first ball/flipper overlap of a frame and reports it as a single
// flat or diagonal collision event at the following frame boundary.
module flipper_ball_collision
    import pinball_pkg::*;
#(
    parameter int HOLDOFF_FRAMES = 2,
    parameter int CENTER_X       = DEFAULT_CENTER_X
) (
    input logic                     clk,
    input logic                     resetN,
    flipper_ball_collision_if.slave bus
);

    coll_state_t      state, state_nxt;
    hit_rec_t         cap;
    logic             overlap;
    logic             capture_en;
    logic             report;
    logic             hold_load;
    logic             hold_done;

    logic             coll_flat_q;
    logic             coll_diag_q;
    logic [PIX_W-1:0] hit_x_q;
    logic [PIX_W-1:0] hit_y_q;
    logic             hit_side_q;
    logic [7:0]       hit_count_q;

    assign overlap = bus.ballDrawReq && (bus.flipperDrawReq || bus.diagonalFlipperDrawReq);

    frame_holdoff_counter u_holdoff (
        .clk      (clk),
        .resetN   (resetN),
        .load     (hold_load),
        .load_val (HOLD_W'(HOLDOFF_FRAMES)),
        .en       (bus.startOfFrame),
        .done     (hold_done)
    );

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) state <= ARMED;
        else         state <= state_nxt;
    end

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        state_nxt  = state;
        capture_en = 1'b0;
        report     = 1'b0;
        hold_load  = 1'b0;
        unique case (state)
            ARMED: begin
                // Overlaps on the frame-boundary cycle belong to neither frame.
                if (overlap && !bus.startOfFrame) begin
                    capture_en = 1'b1;
                    state_nxt  = CAPTURED;
                end
            end
            CAPTURED: begin
                if (bus.startOfFrame) begin
                    report    = 1'b1;
                    hold_load = 1'b1;
                    state_nxt = (HOLDOFF_FRAMES == 0) ? ARMED : HOLDOFF;
                end
            end
            HOLDOFF: begin
                if (hold_done) state_nxt = ARMED;
            end
            default: state_nxt = ARMED;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            cap <= '0;
        end else if (capture_en) begin
            cap.kind <= classify_hit(bus.diagonalFlipperDrawReq);
            cap.x    <= bus.pixelX;
            cap.y    <= bus.pixelY;
        end
    end

    // Report registers: pulses clear every cycle, hit coordinates hold until the next report.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            coll_flat_q <= 1'b0;
            coll_diag_q <= 1'b0;
            hit_x_q     <= '0;
            hit_y_q     <= '0;
            hit_side_q  <= 1'b0;
            hit_count_q <= '0;
        end else begin
            coll_flat_q <= report && (cap.kind == HIT_FLAT);
            coll_diag_q <= report && (cap.kind == HIT_DIAG);
            if (report) begin
                hit_x_q    <= cap.x;
                hit_y_q    <= cap.y;
                hit_side_q <= (cap.x >= PIX_W'(CENTER_X));
                if (hit_count_q != 8'hFF) hit_count_q <= hit_count_q + 8'd1;
            end
        end
    end

    assign bus.collisionFlat = coll_flat_q;
    assign bus.collisionDiag = coll_diag_q;
    assign bus.hitX          = hit_x_q;
    assign bus.hitY          = hit_y_q;
    assign bus.hitSide       = hit_side_q;
    assign bus.hitCount      = hit_count_q;

endmodule
